// File: rtl/march_sequencer_if.sv
// Bus between the March C- sequencer and its memory/controller environment.
// The master side is the sequencer; the slave side drives start/abort and read data.
interface march_sequencer_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              start;
    logic              abort;
    logic [DATA_W-1:0] mem_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic              busy;
    logic              done;
    logic              fail;
    logic [ADDR_W-1:0] fail_addr;
    logic [2:0]        fail_elem;
    logic [7:0]        fail_count;

    modport master (
        input  start, abort, mem_rdata,
        output mem_addr, mem_wdata, mem_we, mem_re,
        output busy, done, fail, fail_addr, fail_elem, fail_count
    );

    modport slave (
        output start, abort, mem_rdata,
        input  mem_addr, mem_wdata, mem_we, mem_re,
        input  busy, done, fail, fail_addr, fail_elem, fail_count
    );
endinterface

// File: rtl/march_sequencer.sv
// March C- sequencer: walks a synchronous read-first memory through six March
// elements, one operation per cycle, and records first/total miscompares.
module march_sequencer #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input logic               clk,
    input logic               rst,
    march_sequencer_if.master bus
);
    // state | meaning
    // IDLE  | waiting for start, memory quiet
    // RUN   | issuing one March operation per cycle
    // DRAIN | comparing the data of the final E5 read
    // DONE  | results valid, waiting for restart
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [2:0]        ELEM_LAST = 3'd5;

    state_t            state_q, state_d;
    logic [2:0]        elem_q, elem_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              phase_q, phase_d;
    logic              cmp_vld_q, cmp_vld_d;
    logic              cmp_exp_q, cmp_exp_d;
    logic [ADDR_W-1:0] cmp_addr_q, cmp_addr_d;
    logic [2:0]        cmp_elem_q, cmp_elem_d;
    logic              fail_q, fail_d;
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
    logic [2:0]        fail_elem_q, fail_elem_d;
    logic [7:0]        fail_cnt_q, fail_cnt_d;

    logic       elem_down, elem_two, op_read, read_bg, write_bg;
    logic       addr_end, op_last, run_end, start_run, miscmp;
    logic [2:0] elem_nxt;

    // E1..E4 are read-then-write pairs; E3/E4 walk downward.
    assign elem_down = (elem_q == 3'd3) || (elem_q == 3'd4);
    assign elem_two  = (elem_q >= 3'd1) && (elem_q <= 3'd4);
    assign op_read   = (elem_q != 3'd0) && !phase_q;
    assign read_bg   = (elem_q == 3'd2) || (elem_q == 3'd4);
    assign write_bg  = (elem_q == 3'd1) || (elem_q == 3'd3);
    assign addr_end  = elem_down ? (addr_q == '0) : (addr_q == ADDR_LAST);
    assign op_last   = !elem_two || phase_q;
    assign run_end   = (elem_q == ELEM_LAST) && addr_end;
    assign elem_nxt  = elem_q + 3'd1;
    assign start_run = bus.start && ((state_q == IDLE) || (state_q == DONE));
    assign miscmp    = cmp_vld_q && !bus.abort
                       && (bus.mem_rdata != {DATA_W{cmp_exp_q}});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN: begin
                if (bus.abort)              state_d = IDLE;
                else if (op_last && run_end) state_d = DRAIN;
            end
            DRAIN:   state_d = bus.abort ? IDLE : DONE;
            DONE:    if (bus.start) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.mem_we    = 1'b0;
        bus.mem_re    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (state_q == RUN) begin
            bus.mem_addr = addr_q;
            if (!bus.abort) begin
                bus.mem_we    = !op_read;
                bus.mem_re    = op_read;
                bus.mem_wdata = op_read ? '0 : {DATA_W{write_bg}};
            end
        end
        bus.busy = (state_q == RUN) || (state_q == DRAIN);
        bus.done = (state_q == DONE);
    end

    always_comb begin
        elem_d      = elem_q;
        addr_d      = addr_q;
        phase_d     = phase_q;
        cmp_vld_d   = 1'b0;
        cmp_exp_d   = cmp_exp_q;
        cmp_addr_d  = cmp_addr_q;
        cmp_elem_d  = cmp_elem_q;
        fail_d      = fail_q;
        fail_addr_d = fail_addr_q;
        fail_elem_d = fail_elem_q;
        fail_cnt_d  = fail_cnt_q;
        if (start_run) begin
            elem_d      = '0;
            addr_d      = '0;
            phase_d     = 1'b0;
            fail_d      = 1'b0;
            fail_addr_d = '0;
            fail_elem_d = '0;
            fail_cnt_d  = '0;
        end else begin
            if ((state_q == RUN) && !bus.abort) begin
                cmp_vld_d  = op_read;
                cmp_exp_d  = read_bg;
                cmp_addr_d = addr_q;
                cmp_elem_d = elem_q;
                if (!op_last) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (!addr_end) begin
                        addr_d = elem_down ? addr_q - ADDR_ONE : addr_q + ADDR_ONE;
                    end else if (elem_q != ELEM_LAST) begin
                        elem_d = elem_nxt;
                        addr_d = ((elem_nxt == 3'd3) || (elem_nxt == 3'd4)) ? ADDR_LAST : '0;
                    end
                end
            end
            // Compare stage trails the read by one cycle, so it spans element edges and DRAIN.
            if (miscmp) begin
                fail_d = 1'b1;
                if (fail_cnt_q != 8'hFF) fail_cnt_d = fail_cnt_q + 8'd1;
                if (!fail_q) begin
                    fail_addr_d = cmp_addr_q;
                    fail_elem_d = cmp_elem_q;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            elem_q      <= '0;
            addr_q      <= '0;
            phase_q     <= 1'b0;
            cmp_vld_q   <= 1'b0;
            cmp_exp_q   <= 1'b0;
            cmp_addr_q  <= '0;
            cmp_elem_q  <= '0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_elem_q <= '0;
            fail_cnt_q  <= '0;
        end else begin
            elem_q      <= elem_d;
            addr_q      <= addr_d;
            phase_q     <= phase_d;
            cmp_vld_q   <= cmp_vld_d;
            cmp_exp_q   <= cmp_exp_d;
            cmp_addr_q  <= cmp_addr_d;
            cmp_elem_q  <= cmp_elem_d;
            fail_q      <= fail_d;
            fail_addr_q <= fail_addr_d;
            fail_elem_q <= fail_elem_d;
            fail_cnt_q  <= fail_cnt_d;
        end
    end

    assign bus.fail       = fail_q;
    assign bus.fail_addr  = fail_addr_q;
    assign bus.fail_elem  = fail_elem_q;
    assign bus.fail_count = fail_cnt_q;
endmodule
